// File: rtl/rl_ram_1r1w_rdport.sv
// Read-port controller for a 1R1W RAM with one-cycle read latency: in-order responses
// through a 2-entry buffer, with write-first merge of a write colliding in the issue cycle.
module rl_ram_1r1w_rdport #(
   parameter int ABITS = 10,
   parameter int DBITS = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [ABITS-1:0]         req_addr_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   output logic [DBITS-1:0]         rsp_data_o,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [ABITS-1:0]         ram_raddr_o,
   output logic                     ram_re_o,
   input  logic [DBITS-1:0]         ram_dout_i,
   input  logic [ABITS-1:0]         wr_addr_i,
   input  logic [DBITS-1:0]         wr_din_i,
   input  logic                     wr_we_i,
   input  logic [(DBITS+7)/8-1:0]   wr_be_i
);
   localparam int NB = (DBITS + 7) / 8;

   logic             r_inflight;
   logic [1:0]       r_count;
   logic             r_wptr;
   logic             r_rptr;
   logic [NB-1:0]    r_mask;
   logic [DBITS-1:0] r_mdat;
   logic [DBITS-1:0] r_buf [2];

   logic             w_fire;
   logic             w_pop;
   logic             w_room;
   logic             w_hit;
   logic [DBITS-1:0] w_ret;

   // Occupancy counts the read in flight so the buffer can never overflow.
   assign w_room      = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
   assign rsp_valid_o = ~rst_i & (r_count != 2'd0);
   assign w_pop       = rsp_valid_o & rsp_ready_i;
   assign req_ready_o = ~rst_i & (w_room | w_pop);
   assign w_fire      = req_valid_i & req_ready_o;
   assign ram_re_o    = w_fire;
   assign ram_raddr_o = req_addr_i;
   assign rsp_data_o  = r_buf[r_rptr];
   assign w_hit       = w_fire & wr_we_i & (wr_addr_i == req_addr_i);

   always_comb begin
      w_ret = ram_dout_i;
      for (int b = 0; b < DBITS; b++) begin
         if (r_mask[b / 8]) begin
            w_ret[b] = r_mdat[b];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_mask     <= '0;
         r_mdat     <= '0;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
      end else begin
         r_inflight <= w_fire;
         if (w_hit) begin
            r_mask <= wr_be_i;
            r_mdat <= wr_din_i;
         end else begin
            r_mask <= '0;
         end
         if (r_inflight) begin
            r_buf[r_wptr] <= w_ret;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
